// File: rtl/alarm_ctrl.sv
// Intrusion alarm controller: synchronizes and debounces the arm/disarm button and the
// intrusion sensor, then runs a five-state arming FSM with a shared exit/entry delay timer.
module alarm_ctrl #(
    parameter int unsigned DEBOUNCE_CYC    = 1000000,
    parameter int unsigned ARM_DELAY_CYC   = 500000000,
    parameter int unsigned ENTRY_DELAY_CYC = 500000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnRaw,
    input  logic       sensorRaw,
    output logic       sysActive,
    output logic       armed,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StDisarmed = 3'd0,
        StArming   = 3'd1,
        StArmed    = 3'd2,
        StEntry    = 3'd3,
        StAlarm    = 3'd4
    } state_e;

    // Counter only ever holds values up to DEBOUNCE_CYC, so size it to that.
    localparam int unsigned DbW =
        (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DbW-1:0] DbThresh = DbW'(DEBOUNCE_CYC);

    // A zero delay behaves like a one-cycle delay.
    localparam logic [31:0] ArmLoad =
        (ARM_DELAY_CYC == 0) ? 32'd0 : 32'(ARM_DELAY_CYC - 1);
    localparam logic [31:0] EntryLoad =
        (ENTRY_DELAY_CYC == 0) ? 32'd0 : 32'(ENTRY_DELAY_CYC - 1);

    // Bit 0 carries the button, bit 1 the sensor.
    logic [1:0]     w_raw;
    logic [1:0]     r_sync1;
    logic [1:0]     r_sync2;
    logic [DbW-1:0] r_db_cnt [2];
    logic [DbW-1:0] w_db_cnt_next [2];
    logic [1:0]     r_db;
    logic [1:0]     w_db_next;
    logic           r_btn_db_prev;
    logic           w_press;
    logic           w_sensor;

    state_e         r_state;
    state_e         w_state_next;
    logic [31:0]    r_timer;
    logic [31:0]    w_timer_next;
    logic           w_expired;
    logic           r_sys_active;
    logic           r_armed;

    assign w_raw = {sensorRaw, btnRaw};

    // Two-flop synchronizers for both asynchronous inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce next-state: count while the sample disagrees, accept on reaching the threshold.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_db_next[i]     = r_db[i];
            w_db_cnt_next[i] = '0;
            if (r_sync2[i] != r_db[i]) begin
                if (r_db_cnt[i] + DbW'(1) >= DbThresh) begin
                    w_db_next[i] = r_sync2[i];
                end else begin
                    w_db_cnt_next[i] = r_db_cnt[i] + DbW'(1);
                end
            end
        end
    end

    // Debounced values, their counters and the button history for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db          <= 2'b00;
            r_db_cnt[0]   <= '0;
            r_db_cnt[1]   <= '0;
            r_btn_db_prev <= 1'b0;
        end else begin
            r_db          <= w_db_next;
            r_db_cnt[0]   <= w_db_cnt_next[0];
            r_db_cnt[1]   <= w_db_cnt_next[1];
            r_btn_db_prev <= r_db[0];
        end
    end

    // One-cycle press pulse on the rising edge of the debounced button.
    assign w_press   = r_db[0] & ~r_btn_db_prev;
    assign w_sensor  = r_db[1];
    assign w_expired = (r_timer == 32'd0);

    // Next-state logic; a press always wins over expiry or a sensor trip.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StDisarmed: begin
                if (w_press) w_state_next = StArming;
            end
            StArming: begin
                if (w_press)        w_state_next = StDisarmed;
                else if (w_expired) w_state_next = StArmed;
            end
            StArmed: begin
                if (w_press)       w_state_next = StDisarmed;
                else if (w_sensor) w_state_next = StEntry;
            end
            StEntry: begin
                if (w_press)        w_state_next = StDisarmed;
                else if (w_expired) w_state_next = StAlarm;
            end
            StAlarm: begin
                if (w_press) w_state_next = StDisarmed;
            end
            default: w_state_next = StDisarmed;
        endcase
    end

    // Shared delay timer: load on entry to a timed state, otherwise count down to zero.
    always_comb begin
        w_timer_next = (r_timer != 32'd0) ? r_timer - 32'd1 : 32'd0;
        if (w_state_next == StArming && r_state != StArming) begin
            w_timer_next = ArmLoad;
        end else if (w_state_next == StEntry && r_state != StEntry) begin
            w_timer_next = EntryLoad;
        end
    end

    // State register, timer and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StDisarmed;
            r_timer      <= 32'd0;
            r_sys_active <= 1'b0;
            r_armed      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_timer      <= w_timer_next;
            r_sys_active <= (w_state_next == StAlarm);
            r_armed      <= (w_state_next == StArmed) || (w_state_next == StEntry);
        end
    end

    assign sysActive = r_sys_active;
    assign armed     = r_armed;
    assign state     = r_state;

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 1000000, cycles an input must hold stable before it is accepted (20 ms at 50 MHz).
REQ-002 Parameter ARM_DELAY_CYC, default 500000000, exit delay between the arm press and armed (10 s).
REQ-003 Parameter ENTRY_DELAY_CYC, default 500000000, delay between a sensor trip and alarm (10 s).
REQ-004 Port clk, input, 1, system clock (50 MHz).
REQ-005 Port rst, input, 1, reset; one clock; reset is synchronous and active-high.
REQ-006 Port btnRaw, input, 1, asynchronous arm/disarm pushbutton, active-high.
REQ-007 Port sensorRaw, input, 1, asynchronous intrusion sensor, active-high.
REQ-008 Port sysActive, output, 1, alarm active; drives the sysActive input of the beep/blink block.
REQ-009 Port armed, output, 1, status LED; high in ARMED and ENTRY.
REQ-010 Port state, output, 3, current FSM state encoding.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-012 Each synchronized input SHALL have its own debouncer: a counter clears whenever the sample equals the debounced value and increments otherwise; the debounced value takes the sample on the cycle the counter reaches DEBOUNCE_CYC.
REQ-013 Total latency from a clean raw edge to the debounced change SHALL be 2 + DEBOUNCE_CYC cycles; a glitch shorter than DEBOUNCE_CYC cycles SHALL NOT change the debounced value.
REQ-014 A press event SHALL be a one-cycle pulse on the 0->1 transition of the debounced button; a held button SHALL produce one event only.
REQ-015 FSM states and encodings SHALL be DISARMED=0, ARMING=1, ARMED=2, ENTRY=3, ALARM=4; codes 5-7 SHALL go to DISARMED on the next cycle.
REQ-016 DISARMED: a press SHALL go to ARMING; the sensor SHALL be ignored.
REQ-017 ARMING: a press SHALL go to DISARMED; timer expiry SHALL go to ARMED; the sensor SHALL be ignored.
REQ-018 ARMED: a press SHALL go to DISARMED; debounced sensor high SHALL go to ENTRY.
REQ-019 ENTRY: a press SHALL go to DISARMED; timer expiry SHALL go to ALARM; a sensor release SHALL NOT cancel ENTRY.
REQ-020 ALARM: a press SHALL go to DISARMED; no other exit.
REQ-021 On entry to ARMING or ENTRY, a shared 32-bit down-counter SHALL load DELAY-1, where a parameter value of 0 is treated as 1. It SHALL decrement each cycle, and expiry SHALL occur on the cycle it reads 0, so the FSM spends exactly DELAY cycles in that state.
REQ-022 A press SHALL take priority over simultaneous timer expiry or sensor trip.
REQ-023 When ARMED is entered with the sensor already high, the FSM SHALL go to ENTRY on the next cycle.
REQ-024 Outputs SHALL be registered: sysActive=1 only in ALARM, armed=1 only in ARMED/ENTRY, state=current encoding, all valid the same cycle the state register updates.

Reset
REQ-025 While rst=1 at a clock edge, the block SHALL set: state=DISARMED, sysActive=0, armed=0, synchronizers, debounced values and debounce counters=0, timer=0, press event=0.
REQ-026 Reset asserted mid-operation, including in ALARM or mid-delay, SHALL take effect on the next edge and override all other transitions.
REQ-027 A button still held high when reset releases SHALL generate one press event after debounce, because the debounced value restarts at 0.

Verification
Parameter set for all benches: DEBOUNCE_CYC=4, ARM_DELAY_CYC=10, ENTRY_DELAY_CYC=8.
REQ-028 Debounce: btnRaw pulse of 3 cycles -> state stays 0. Held 10 cycles -> state=1 exactly 7 cycles after the raw edge.
REQ-029 Full path: press, wait -> state 1 for 10 cycles, then 2 (armed=1). sensorRaw high -> state 3 after debounce. After 8 cycles -> state 4, sysActive=1, armed=0.
REQ-030 Disarm: press in each of states 1, 2, 3, 4 -> state 0, sysActive=0, armed=0 on the cycle after the press event.
REQ-031 Priority: press event on the exact expiry cycle of ARMING -> state 0, not 2. Sensor held high throughout ARMING -> state 2 for one cycle, then 3.
REQ-032 Reset: rst pulse while in ALARM -> next cycle state=0, sysActive=0. Button held through reset release -> exactly one press event, ending in state=1.
